// File: rtl/dmem_dual_issue_sched_if.sv
// dmem_dual_issue_sched_if: bundles the two lane request/response channels, the memory port and status lines (slave = scheduler, master = core+memory side)
interface dmem_dual_issue_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
);
  logic req_valid_0, req_valid_1;
  logic [2:0] req_wr_0, req_wr_1, req_rd_0, req_rd_1;
  logic [ADDR_W-1:0] req_addr_0, req_addr_1;
  logic [DATA_W-1:0] req_wdata_0, req_wdata_1;
  logic req_ready_0, req_ready_1;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0] mem_write, mem_read;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic resp_valid_0, resp_valid_1;
  logic [DATA_W-1:0] resp_data_0, resp_data_1;
  logic stall_o;
  logic [CNT_W-1:0] conflict_cnt;
  logic fault_o;
  modport slave (
    input req_valid_0, req_wr_0, req_rd_0, req_addr_0, req_wdata_0,
    input req_valid_1, req_wr_1, req_rd_1, req_addr_1, req_wdata_1,
    input mem_rdata,
    output req_ready_0, req_ready_1, mem_addr, mem_write, mem_read, mem_wdata,
    output resp_valid_0, resp_data_0, resp_valid_1, resp_data_1, stall_o, conflict_cnt, fault_o
  );
  modport master (
    output req_valid_0, req_wr_0, req_rd_0, req_addr_0, req_wdata_0,
    output req_valid_1, req_wr_1, req_rd_1, req_addr_1, req_wdata_1,
    output mem_rdata,
    input req_ready_0, req_ready_1, mem_addr, mem_write, mem_read, mem_wdata,
    input resp_valid_0, resp_data_0, resp_valid_1, resp_data_1, stall_o, conflict_cnt, fault_o
  );
endinterface

// File: rtl/dmem_dual_issue_sched.sv
// dmem_dual_issue_sched: serializes two lanes onto one memory port (lane 0 first), stalls during the held lane 1 issue, returns registered load data. Ports: clk, rst (async high), bus (slave). Optional macro DMEM_ALIGN_CHK_EN enables misalignment suppression and fault_o.
module dmem_dual_issue_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  dmem_dual_issue_sched_if.slave bus
);
  typedef enum logic {IDLE, HOLD1} state_t;
  state_t state;
  logic [2:0] h_wr, h_rd, i_wr, i_rd, e_rd;
  logic [ADDR_W-1:0] h_addr, i_addr;
  logic [DATA_W-1:0] h_wdata, i_wdata;
  logic pick1, any, mis;
  always_comb begin
    pick1 = (state == HOLD1) | ~bus.req_valid_0;
    any = ~rst & ((state == HOLD1) | bus.req_valid_0 | bus.req_valid_1);
    i_wr = (state == HOLD1) ? h_wr : bus.req_valid_0 ? bus.req_wr_0 : bus.req_wr_1;
    i_rd = (state == HOLD1) ? h_rd : bus.req_valid_0 ? bus.req_rd_0 : bus.req_rd_1;
    i_addr = (state == HOLD1) ? h_addr : bus.req_valid_0 ? bus.req_addr_0 : bus.req_addr_1;
    i_wdata = (state == HOLD1) ? h_wdata : bus.req_valid_0 ? bus.req_wdata_0 : bus.req_wdata_1;
    e_rd = (i_wr != 3'b000) ? 3'b000 : i_rd;
`ifdef DMEM_ALIGN_CHK_EN
    mis = any & ((((i_wr == 3'b010) | (e_rd == 3'b010) | (e_rd == 3'b100)) & i_addr[0]) |
                 (((i_wr == 3'b100) | (e_rd == 3'b101)) & (|i_addr[1:0])));
`else
    mis = 1'b0;
`endif
    bus.mem_write = (any & ~mis) ? i_wr : 3'b000;
    bus.mem_read = (any & ~mis) ? e_rd : 3'b000;
    bus.mem_addr = any ? i_addr : '0;
    bus.mem_wdata = any ? i_wdata : '0;
    bus.req_ready_0 = ~rst & (state == IDLE) & bus.req_valid_0;
    bus.req_ready_1 = ~rst & (state == IDLE) & bus.req_valid_1;
    bus.stall_o = (state == HOLD1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_wr <= '0;
      h_rd <= '0;
      h_addr <= '0;
      h_wdata <= '0;
      bus.resp_valid_0 <= 1'b0;
      bus.resp_valid_1 <= 1'b0;
      bus.resp_data_0 <= '0;
      bus.resp_data_1 <= '0;
      bus.conflict_cnt <= '0;
      bus.fault_o <= 1'b0;
    end else begin
      bus.resp_valid_0 <= (bus.mem_read != 3'b000) & ~pick1;
      bus.resp_valid_1 <= (bus.mem_read != 3'b000) & pick1;
      if ((bus.mem_read != 3'b000) & ~pick1) bus.resp_data_0 <= bus.mem_rdata;
      if ((bus.mem_read != 3'b000) & pick1) bus.resp_data_1 <= bus.mem_rdata;
      bus.fault_o <= mis;
      if (state == HOLD1) state <= IDLE;
      else if (bus.req_valid_0 & bus.req_valid_1) begin
        state <= HOLD1;
        h_wr <= bus.req_wr_1;
        h_rd <= bus.req_rd_1;
        h_addr <= bus.req_addr_1;
        h_wdata <= bus.req_wdata_1;
        if (~&bus.conflict_cnt) bus.conflict_cnt <= bus.conflict_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmem_dual_issue_sched.sv
// tb_dmem_dual_issue_sched: directed self-checking bench with a small word memory model
module tb_dmem_dual_issue_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  logic [31:0] mem [0:63];
  dmem_dual_issue_sched_if b ();
  dmem_dual_issue_sched dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  assign b.mem_rdata = mem[b.mem_addr[7:2]];
  always @(posedge clk) begin
    if (b.mem_write == 3'b100) mem[b.mem_addr[7:2]] <= b.mem_wdata;
    else if (b.mem_write == 3'b010) mem[b.mem_addr[7:2]][b.mem_addr[1]*16 +: 16] <= b.mem_wdata[15:0];
    else if (b.mem_write == 3'b001) mem[b.mem_addr[7:2]][b.mem_addr[1:0]*8 +: 8] <= b.mem_wdata[7:0];
  end

  task automatic idle_lanes();
    b.req_valid_0 = 0; b.req_wr_0 = 0; b.req_rd_0 = 0; b.req_addr_0 = 0; b.req_wdata_0 = 0;
    b.req_valid_1 = 0; b.req_wr_1 = 0; b.req_rd_1 = 0; b.req_addr_1 = 0; b.req_wdata_1 = 0;
  endtask

  task automatic lane0(input logic [2:0] wr, input logic [2:0] rd, input logic [31:0] a, input logic [31:0] d);
    b.req_valid_0 = 1; b.req_wr_0 = wr; b.req_rd_0 = rd; b.req_addr_0 = a; b.req_wdata_0 = d;
  endtask

  task automatic lane1(input logic [2:0] wr, input logic [2:0] rd, input logic [31:0] a, input logic [31:0] d);
    b.req_valid_1 = 1; b.req_wr_1 = wr; b.req_rd_1 = rd; b.req_addr_1 = a; b.req_wdata_1 = d;
  endtask

  task automatic test_reset();
    idle_lanes();
    lane0(3'b100, 3'b000, 32'h8000_0010, 32'h1);
    rst = 1;
    #1;
    vec++; if (b.req_ready_0 !== 1'b0) begin miss++; $display("FAIL reset_ready0 got %b exp 0", b.req_ready_0); end
    vec++; if (b.mem_write !== 3'b000) begin miss++; $display("FAIL reset_mem_write got %b exp 000", b.mem_write); end
    vec++; if (b.stall_o !== 1'b0) begin miss++; $display("FAIL reset_stall got %b exp 0", b.stall_o); end
    vec++; if ({b.resp_valid_0, b.resp_valid_1, b.fault_o} !== 3'b000) begin miss++; $display("FAIL reset_resp_fault got %b exp 000", {b.resp_valid_0, b.resp_valid_1, b.fault_o}); end
    vec++; if (b.conflict_cnt !== 16'd0) begin miss++; $display("FAIL reset_cnt got %0d exp 0", b.conflict_cnt); end
    @(negedge clk); idle_lanes(); rst = 0;
  endtask

  task automatic test_single_lane();
    @(negedge clk); lane0(3'b100, 3'b000, 32'h8000_0010, 32'hDEAD_BEEF); #1;
    vec++; if (b.mem_write !== 3'b100) begin miss++; $display("FAIL single_sw_op got %b exp 100", b.mem_write); end
    vec++; if (b.mem_addr !== 32'h8000_0010) begin miss++; $display("FAIL single_sw_addr got %h exp 80000010", b.mem_addr); end
    vec++; if (b.req_ready_0 !== 1'b1) begin miss++; $display("FAIL single_ready0 got %b exp 1", b.req_ready_0); end
    @(negedge clk); lane0(3'b000, 3'b101, 32'h8000_0010, 32'h0); #1;
    vec++; if (b.mem_read !== 3'b101) begin miss++; $display("FAIL single_lw_op got %b exp 101", b.mem_read); end
    vec++; if (b.stall_o !== 1'b0) begin miss++; $display("FAIL single_stall got %b exp 0", b.stall_o); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.resp_valid_0 !== 1'b1 || b.resp_data_0 !== 32'hDEAD_BEEF) begin miss++; $display("FAIL single_resp got %b/%h exp 1/deadbeef", b.resp_valid_0, b.resp_data_0); end
    vec++; if (b.mem_read !== 3'b000 || b.mem_write !== 3'b000) begin miss++; $display("FAIL single_idle_ops got %b/%b exp 000/000", b.mem_read, b.mem_write); end
    @(negedge clk); #1;
    vec++; if (b.resp_valid_0 !== 1'b0 || b.resp_data_0 !== 32'hDEAD_BEEF) begin miss++; $display("FAIL single_resp_hold got %b/%h exp 0/deadbeef", b.resp_valid_0, b.resp_data_0); end
  endtask

  task automatic test_dual_store_load();
    @(negedge clk); lane0(3'b100, 3'b000, 32'h8000_0020, 32'h1234_5678); lane1(3'b000, 3'b101, 32'h8000_0020, 32'h0); #1;
    vec++; if (b.mem_write !== 3'b100 || b.mem_wdata !== 32'h1234_5678) begin miss++; $display("FAIL dual_sl_issue0 got %b/%h exp 100/12345678", b.mem_write, b.mem_wdata); end
    vec++; if ({b.req_ready_0, b.req_ready_1} !== 2'b11) begin miss++; $display("FAIL dual_sl_ready got %b exp 11", {b.req_ready_0, b.req_ready_1}); end
    vec++; if (b.stall_o !== 1'b0) begin miss++; $display("FAIL dual_sl_stall_n got %b exp 0", b.stall_o); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.stall_o !== 1'b1) begin miss++; $display("FAIL dual_sl_stall got %b exp 1", b.stall_o); end
    vec++; if (b.mem_read !== 3'b101 || b.mem_write !== 3'b000 || b.mem_addr !== 32'h8000_0020) begin miss++; $display("FAIL dual_sl_issue1 got %b/%b/%h exp 101/000/80000020", b.mem_read, b.mem_write, b.mem_addr); end
    @(negedge clk); #1;
    vec++; if (b.resp_valid_1 !== 1'b1 || b.resp_data_1 !== 32'h1234_5678 || b.resp_valid_0 !== 1'b0) begin miss++; $display("FAIL dual_sl_resp1 got %b/%h/%b exp 1/12345678/0", b.resp_valid_1, b.resp_data_1, b.resp_valid_0); end
    vec++; if (b.conflict_cnt !== 16'd1) begin miss++; $display("FAIL dual_sl_cnt got %0d exp 1", b.conflict_cnt); end
    vec++; if (b.stall_o !== 1'b0) begin miss++; $display("FAIL dual_sl_stall_end got %b exp 0", b.stall_o); end
  endtask

  task automatic test_dual_loads();
    @(negedge clk); lane0(3'b000, 3'b101, 32'h8000_0000, 32'h0); lane1(3'b000, 3'b101, 32'h8000_0004, 32'h0); #1;
    vec++; if (b.mem_read !== 3'b101 || b.mem_addr !== 32'h8000_0000) begin miss++; $display("FAIL dual_ll_issue0 got %b/%h exp 101/80000000", b.mem_read, b.mem_addr); end
    @(negedge clk); #1;
    vec++; if ({b.req_ready_0, b.req_ready_1} !== 2'b00) begin miss++; $display("FAIL dual_ll_ready got %b exp 00", {b.req_ready_0, b.req_ready_1}); end
    vec++; if (b.resp_valid_0 !== 1'b1 || b.resp_data_0 !== 32'hA) begin miss++; $display("FAIL dual_ll_resp0 got %b/%h exp 1/a", b.resp_valid_0, b.resp_data_0); end
    vec++; if (b.mem_addr !== 32'h8000_0004) begin miss++; $display("FAIL dual_ll_addr1 got %h exp 80000004", b.mem_addr); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.resp_valid_1 !== 1'b1 || b.resp_data_1 !== 32'hB || b.resp_valid_0 !== 1'b0) begin miss++; $display("FAIL dual_ll_resp1 got %b/%h/%b exp 1/b/0", b.resp_valid_1, b.resp_data_1, b.resp_valid_0); end
    vec++; if (b.conflict_cnt !== 16'd2) begin miss++; $display("FAIL dual_ll_cnt got %0d exp 2", b.conflict_cnt); end
  endtask

  task automatic test_store_precedence();
    @(negedge clk); lane0(3'b100, 3'b101, 32'h8000_0030, 32'h55AA_55AA); #1;
    vec++; if (b.mem_write !== 3'b100 || b.mem_read !== 3'b000) begin miss++; $display("FAIL prec_ops got %b/%b exp 100/000", b.mem_write, b.mem_read); end
    @(negedge clk); idle_lanes(); lane1(3'b000, 3'b101, 32'h8000_0030, 32'h0); #1;
    vec++; if (b.resp_valid_0 !== 1'b0) begin miss++; $display("FAIL prec_no_resp got %b exp 0", b.resp_valid_0); end
    vec++; if (b.req_ready_1 !== 1'b1 || b.mem_read !== 3'b101) begin miss++; $display("FAIL prec_lane1_issue got %b/%b exp 1/101", b.req_ready_1, b.mem_read); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.resp_valid_1 !== 1'b1 || b.resp_data_1 !== 32'h55AA_55AA) begin miss++; $display("FAIL prec_stored got %b/%h exp 1/55aa55aa", b.resp_valid_1, b.resp_data_1); end
  endtask

  task automatic test_null_op();
    @(negedge clk); lane1(3'b000, 3'b000, 32'h8000_0000, 32'h0); #1;
    vec++; if (b.req_ready_1 !== 1'b1 || b.mem_write !== 3'b000 || b.mem_read !== 3'b000) begin miss++; $display("FAIL null_issue got %b/%b/%b exp 1/000/000", b.req_ready_1, b.mem_write, b.mem_read); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if ({b.resp_valid_0, b.resp_valid_1} !== 2'b00) begin miss++; $display("FAIL null_no_resp got %b exp 00", {b.resp_valid_0, b.resp_valid_1}); end
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk); lane0(3'b000, 3'b101, 32'h8000_0000, 32'h0); lane1(3'b100, 3'b000, 32'h8000_0004, 32'hFFFF_0000);
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.stall_o !== 1'b1 || b.conflict_cnt !== 16'd3) begin miss++; $display("FAIL rsth_pre got %b/%0d exp 1/3", b.stall_o, b.conflict_cnt); end
    rst = 1; #1;
    vec++; if (b.stall_o !== 1'b0 || b.mem_write !== 3'b000 || b.conflict_cnt !== 16'd0) begin miss++; $display("FAIL rsth_during got %b/%b/%0d exp 0/000/0", b.stall_o, b.mem_write, b.conflict_cnt); end
    vec++; if ({b.resp_valid_0, b.resp_valid_1} !== 2'b00) begin miss++; $display("FAIL rsth_resp got %b exp 00", {b.resp_valid_0, b.resp_valid_1}); end
    @(negedge clk); rst = 0; #1;
    vec++; if (b.stall_o !== 1'b0 || b.mem_write !== 3'b000 || b.mem_read !== 3'b000) begin miss++; $display("FAIL rsth_after got %b/%b/%b exp 0/000/000", b.stall_o, b.mem_write, b.mem_read); end
    vec++; if (mem[1] !== 32'hB) begin miss++; $display("FAIL rsth_no_store got %h exp b", mem[1]); end
    @(negedge clk); #1;
    vec++; if ({b.resp_valid_0, b.resp_valid_1} !== 2'b00 || b.conflict_cnt !== 16'd0) begin miss++; $display("FAIL rsth_quiet got %b/%0d exp 00/0", {b.resp_valid_0, b.resp_valid_1}, b.conflict_cnt); end
  endtask

  task automatic test_align();
    @(negedge clk); lane0(3'b000, 3'b101, 32'h8000_0002, 32'h0); #1;
`ifdef DMEM_ALIGN_CHK_EN
    vec++; if (b.mem_read !== 3'b000 || b.req_ready_0 !== 1'b1) begin miss++; $display("FAIL align_suppress got %b/%b exp 000/1", b.mem_read, b.req_ready_0); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.fault_o !== 1'b1 || b.resp_valid_0 !== 1'b0) begin miss++; $display("FAIL align_fault got %b/%b exp 1/0", b.fault_o, b.resp_valid_0); end
    @(negedge clk); #1;
    vec++; if (b.fault_o !== 1'b0) begin miss++; $display("FAIL align_fault_pulse got %b exp 0", b.fault_o); end
`else
    vec++; if (b.mem_read !== 3'b101) begin miss++; $display("FAIL noalign_issue got %b exp 101", b.mem_read); end
    @(negedge clk); idle_lanes(); #1;
    vec++; if (b.fault_o !== 1'b0 || b.resp_valid_0 !== 1'b1) begin miss++; $display("FAIL noalign_resp got %b/%b exp 0/1", b.fault_o, b.resp_valid_0); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hA;
    mem[1] = 32'hB;
    test_reset();
    test_single_lane();
    test_dual_store_load();
    test_dual_loads();
    test_store_precedence();
    test_null_op();
    test_reset_in_hold();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/dmem_dual_issue_sched.md
Name: dmem_dual_issue_sched

Overview:
- Scheduler between the two execute lanes of the superscalar core and the single-port data memory.
- Accepts at most one load/store request per lane per cycle and serializes same-cycle requests in program order (lane 0 older).
- Drives the memory's single access port and returns registered load data to the originating lane.
- Raises a pipeline stall while a serialized second access is pending.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- CNT_W, 16, width of saturating conflict counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req_valid_0  input  1  lane 0 request valid
- req_wr_0  input  3  lane 0 store op: 001 SB, 010 SH, 100 SW, 000 none
- req_rd_0  input  3  lane 0 load op: 001 LBU, 010 LHU, 011 LB, 100 LH, 101 LW, 000 none
- req_addr_0  input  ADDR_W  lane 0 byte address
- req_wdata_0  input  DATA_W  lane 0 store data
- req_ready_0  output  1  lane 0 request accepted this cycle
- req_valid_1, req_wr_1, req_rd_1, req_addr_1, req_wdata_1, req_ready_1: lane 1 equivalents
- mem_addr  output  ADDR_W  memory address
- mem_write  output  3  memory store op
- mem_read  output  3  memory load op
- mem_wdata  output  DATA_W  memory store data
- mem_rdata  input  DATA_W  combinational memory read data
- resp_valid_0  output  1  lane 0 load data valid
- resp_data_0  output  DATA_W  lane 0 load data
- resp_valid_1  output  1  lane 1 load data valid
- resp_data_1  output  DATA_W  lane 1 load data
- stall_o  output  1  hold core front end
- conflict_cnt  output  CNT_W  number of same-cycle dual requests, saturating
- fault_o  output  1  misaligned access flagged (optional feature only)

Behaviour:
- States: IDLE, HOLD1.
- IDLE, no valid request: mem_write = mem_read = 0.
- IDLE, exactly one lane valid: drive that lane's op/addr/wdata to the memory combinationally; assert that lane's ready; stay in IDLE.
- IDLE, both lanes valid:
  - Issue lane 0 this cycle; both ready = 1.
  - Capture lane 1 op/addr/wdata into the hold register; go to HOLD1.
  - conflict_cnt += 1, saturating at all-ones.
- HOLD1:
  - Issue the held lane 1 request; both ready = 0; stall_o = 1 (combinational from state); next state IDLE.
  - New requests presented in HOLD1 are ignored and must be held by the core.
- Ordering: a lane 0 store is written at the edge ending its issue cycle, so a lane 1 load to the same address in HOLD1 returns the new data. No forwarding logic.
- Request with both wr and rd nonzero: store takes precedence; load op forced to 000; no response generated.
- Valid request with wr = rd = 000: accepted (ready = 1), no memory access, no response.
- Responses:
  - Load issued in cycle N -> resp_valid_x = 1 in cycle N+1 for exactly one cycle.
  - resp_data_x = mem_rdata registered at the end of cycle N.
  - resp_data_x holds its last value when resp_valid_x = 0.
  - Stores produce no response.
- Reset, asynchronous:
  - State -> IDLE; hold register cleared; resp_valid_* = 0; resp_data_* = 0; conflict_cnt = 0; fault_o = 0.
  - Memory outputs 0; stall_o = 0; ready_* = 0.
  - A held lane 1 request pending at reset is discarded.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined:
  - Before issue, check alignment of the issuing request: SH/LH/LHU need addr[0] = 0; SW/LW need addr[1:0] = 00.
  - Misaligned: memory ops forced to 000, access suppressed; fault_o = 1 for one cycle in the following cycle; no resp_valid.
  - The request is still accepted and the sequencing is unchanged.
- Undefined: no alignment check; fault_o tied to 0.

Test Plan:
- Lane 0 only, SW addr 0x8000_0010 data 0xDEAD_BEEF, then LW same addr -> mem_write = 100 cycle N; resp_valid_0 = 1 and resp_data_0 = 0xDEAD_BEEF in cycle after the load; stall_o never asserted.
- Both lanes valid: lane 0 SW 0x8000_0020 = 0x1234_5678, lane 1 LW 0x8000_0020 -> lane 0 issues cycle N; stall_o = 1 in N+1; resp_valid_1 = 1 in N+2 with 0x1234_5678; conflict_cnt = 1.
- Both lanes LW (0x8000_0000 -> 0xA, 0x8000_0004 -> 0xB) -> resp_valid_0 = 1 in N+1 with 0xA; resp_valid_1 = 1 in N+2 with 0xB; ready_* = 0 in N+1.
- Assert rst during HOLD1 -> next cycle state IDLE; no lane 1 access issued; resp_valid_* = 0; conflict_cnt = 0.
- Request with wr = 100 and rd = 101 -> store performed; no resp_valid.
- With DMEM_ALIGN_CHK_EN defined: LW at 0x8000_0002 -> mem_read = 000; fault_o = 1 next cycle; resp_valid_0 = 0.
